// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions.
//   - ps2_state_e : frame FSM state encoding (IDLE, DATA, PARITY, STOP)
//   - FRAME_BITS  : bits per PS/2 frame (start + 8 data + parity + stop)
//   - scan-code constants used by the downstream keyboard command decoder
//   - odd_ones()  : odd-parity test over data byte plus parity bit
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] BREAK     = 8'hF0;
  localparam logic [7:0] EXTEND    = 8'hE0;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_P     = 8'h4D;
  localparam logic [7:0] KEY_H     = 8'h33;

  // True when the 9 bits hold an odd number of ones.
  function automatic logic odd_ones(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioning: synchronises both raw pins into the clk domain and
// glitch-filters the PS/2 clock.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   ps2Clk   in   raw PS/2 clock pin (asynchronous)
//   ps2Dat   in   raw PS/2 data pin (asynchronous)
//   dat_s    out  synchronised data line
//   clk_fall out  1-cycle pulse on an accepted falling edge of the filtered clock
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2Clk,
  input  logic ps2Dat,
  output logic dat_s,
  output logic clk_fall
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_s;
  logic                   filt_q;
  logic [CW-1:0]          cnt_q;
  logic                   fall_q;

  // Lines idle high, so the chains reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2Clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2Dat};
    end
  end

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // The filtered level only follows clk_s after FILTER_LEN consecutive
  // samples disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clk_s == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        filt_q <= clk_s;
        cnt_q  <= '0;
        fall_q <= ~clk_s;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign clk_fall = fall_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Publishes the newest good byte on data and the previous one on data2.
// Optional feature macro: PS2_RX_PARITY_CHECK_EN (when defined, frames with
// even parity over data+parity are rejected; otherwise parity is ignored).
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   ps2Clk    in   raw PS/2 clock pin
//   ps2Dat    in   raw PS/2 data pin
//   data      out  most recent good byte
//   data2     out  good byte received before data
//   valid     out  1-cycle pulse when data/data2 update
//   frame_err out  1-cycle pulse on a rejected or abandoned frame
//   busy      out  high while a frame is in progress
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Dat,
  output logic [7:0] data,
  output logic [7:0] data2,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic dat_s;
  logic clk_fall;

  ps2_line_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_line_sync (
    .clk      (clk),
    .reset    (reset),
    .ps2Clk   (ps2Clk),
    .ps2Dat   (ps2Dat),
    .dat_s    (dat_s),
    .clk_fall (clk_fall)
  );

  ps2_state_e      state_q;
  logic [2:0]      cnt_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic [TW-1:0]   tmo_q;
  logic [7:0]      data_q;
  logic [7:0]      data2_q;
  logic            valid_q;
  logic            err_q;
  logic            frame_good_d;

  // Qualifies the frame on the stop-bit edge, using the bit being sampled now.
  always_comb begin
    frame_good_d = dat_s;
`ifdef PS2_RX_PARITY_CHECK_EN
    frame_good_d = dat_s & odd_ones({par_q, shift_q});
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      data_q  <= '0;
      data2_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (clk_fall) begin
        // Any edge restarts the stall timer, so it only measures gaps.
        tmo_q <= '0;
        case (state_q)
          IDLE: begin
            // A high start bit is line noise, not an error.
            if (!dat_s) begin
              state_q <= DATA;
              cnt_q   <= '0;
            end
          end
          DATA: begin
            shift_q[cnt_q] <= dat_s;
            cnt_q          <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= dat_s;
            state_q <= STOP;
          end
          STOP: begin
            if (frame_good_d) begin
              data2_q <= data_q;
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (tmo_q == TMO_LAST) begin
          err_q   <= 1'b1;
          state_q <= IDLE;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign data      = data_q;
  assign data2     = data2_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
module tb_ps2_frame_receiver;
  import ps2_pkg::*;

  localparam int TMO = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2Clk;
  logic       ps2Dat;
  logic [7:0] data;
  logic [7:0] data2;
  logic       valid;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  ps2_frame_receiver #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2Clk    (ps2Clk),
    .ps2Dat    (ps2Dat),
    .data      (data),
    .data2     (data2),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int checks = 0;
  int failures = 0;

  // Pulse monitor, sampled on the falling edge of clk.
  int   vld_cnt = 0;
  int   err_cnt = 0;
  int   both_cnt = 0;
  int   busy_rises = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (valid === 1'b1) vld_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    if (busy === 1'b1 && busy_prev !== 1'b1) busy_rises++;
    busy_prev = busy;
  end

  // Reference model: byte history plus expected pulse totals.
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_data2 = 8'h00;
  int         m_vld = 0;
  int         m_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit par_ok, input bit stop);
    logic p;
    p = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    if (!par_ok) p = ~p;
    return {stop, p, b, 1'b0};
  endfunction

  // Device-style bit timing: data changes while clock is high, held across the fall.
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2Dat = f[i];
      wait_clks(10);
      ps2Clk = 1'b0;
      wait_clks(20);
      ps2Clk = 1'b1;
      wait_clks(10);
    end
  endtask

  task automatic model_frame(input logic [10:0] f);
    bit good;
    good = (f[10] == 1'b1);
`ifdef PS2_RX_PARITY_CHECK_EN
    if ($countones(f[9:1]) % 2 == 0) good = 1'b0;
`endif
    if (good) begin
      m_data2 = m_data;
      m_data  = f[8:1];
      m_vld++;
    end else begin
      m_err++;
    end
  endtask

  task automatic send_and_check(input logic [10:0] f, input string tag);
    send_bits(f, FRAME_BITS);
    ps2Dat = 1'b1;
    wait_clks(40);
    model_frame(f);
    chk({tag, "_valid_cnt"}, vld_cnt, m_vld);
    chk({tag, "_err_cnt"}, err_cnt, m_err);
    chk({tag, "_data"}, {24'h0, data}, {24'h0, m_data});
    chk({tag, "_data2"}, {24'h0, data2}, {24'h0, m_data2});
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int r;
    logic [7:0] b;
    reset  = 1'b1;
    ps2Clk = 1'b1;
    ps2Dat = 1'b1;
    wait_clks(5);
    chk("rst_data", {24'h0, data}, 32'h0);
    chk("rst_data2", {24'h0, data2}, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_err", {31'h0, frame_err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    wait_clks(20);

    send_and_check(mk(KEY_SPACE, 1'b1, 1'b1), "t1");

    send_and_check(mk(KEY_A, 1'b1, 1'b1), "t2a");
    send_and_check(mk(BREAK, 1'b1, 1'b1), "t2b");
    send_and_check(mk(KEY_A, 1'b1, 1'b1), "t2c");

    send_and_check(mk(KEY_P, 1'b0, 1'b1), "t3_badpar");

    // Stalled frame: start plus four data bits, then silence.
    send_bits(mk(8'h55, 1'b1, 1'b1), 5);
    ps2Dat = 1'b1;
    chk("t4_busy_open", {31'h0, busy}, 32'h1);
    wait_clks(200);
    chk("t4_busy_before_tmo", {31'h0, busy}, 32'h1);
    chk("t4_err_before_tmo", err_cnt, m_err);
    wait_clks(150);
    m_err++;
    chk("t4_err_after_tmo", err_cnt, m_err);
    chk("t4_busy_after_tmo", {31'h0, busy}, 32'h0);
    chk("t4_valid_cnt", vld_cnt, m_vld);
    send_and_check(mk(KEY_H, 1'b1, 1'b1), "t4_next");

    // Short low glitches on an idle line must be filtered out.
    r = busy_rises;
    for (int g = 1; g <= 3; g++) begin
      ps2Dat = 1'b0;
      ps2Clk = 1'b0;
      wait_clks(g);
      ps2Clk = 1'b1;
      wait_clks(15);
    end
    ps2Dat = 1'b1;
    wait_clks(10);
    chk("t5_glitch_busy_rises", busy_rises, r);
    chk("t5_glitch_err", err_cnt, m_err);
    chk("t5_glitch_valid", vld_cnt, m_vld);
    send_and_check(mk(KEY_D, 1'b1, 1'b0), "t5_badstop");

    // Reset during bit 6 of a frame.
    send_bits(mk(KEY_A, 1'b1, 1'b1), 7);
    ps2Dat = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("t6_rst_data", {24'h0, data}, 32'h0);
    chk("t6_rst_data2", {24'h0, data2}, 32'h0);
    chk("t6_rst_valid", {31'h0, valid}, 32'h0);
    chk("t6_rst_err", {31'h0, frame_err}, 32'h0);
    chk("t6_rst_busy", {31'h0, busy}, 32'h0);
    m_data  = 8'h00;
    m_data2 = 8'h00;
    wait_clks(20);
    send_and_check(mk(KEY_SPACE, 1'b1, 1'b1), "t6_next");

    // Randomized frames: occasional bad parity / bad stop.
    for (int k = 0; k < 40; k++) begin
      b = 8'($urandom_range(0, 255));
      send_and_check(mk(b, ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) != 0)), "rnd");
    end

    chk("valid_err_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
